// File: rtl/recv_demux_fifo_pkg.sv
// Shared definitions for the receive-side demultiplexer.
//   TYPE_NONE     : data_type value meaning "no word presented"
//   CH_ARP, CH_IP : default channel indices for the two standard receivers
//   rd_state_e    : CPU handshake FSM encoding (RD_IDLE, RD_ACK)
package recv_demux_fifo_pkg;

  localparam int TYPE_NONE = 0;
  localparam int CH_ARP    = 0;
  localparam int CH_IP     = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/recv_demux_fifo_chan_fifo.sv
// recv_chan_fifo: single-clock show-ahead FIFO for one receive channel.
// Ports:
//   clk     in   system clock
//   reset_n in   asynchronous active-low reset (clears pointers, count, storage)
//   push    in   write din this cycle (ignored when full)
//   din     in   DATA_W write data
//   pop     in   discard the head word this cycle (ignored when empty)
//   dout    out  DATA_W head word (holds a stale value when empty)
//   empty   out  no words stored
//   full    out  DEPTH words stored
// All status outputs derive from registered state only.
module recv_chan_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  logic do_push;
  logic do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/recv_demux_fifo.sv
// recv_demux_fifo: routes CPU words into per-channel FIFOs by type code.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   data_in    in   DATA_W CPU write data, stable while data_type != 0
//   data_type  in   TYPE_W 0 = idle, k = 1..NUM_CH -> channel k-1, else invalid
//   data_ack   out  4-phase acknowledge to the CPU
//   out_data   out  NUM_CH*DATA_W, channel c head at [c*DATA_W +: DATA_W]
//   out_valid  out  NUM_CH, channel c head valid
//   out_ready  in   NUM_CH, channel c consumer takes the head this cycle
//   ch_full    out  NUM_CH, channel c FIFO full
//   err_cnt    out  ERR_W saturating count of invalid-type words
// Every output is driven from registers, so no input reaches an output
// combinationally.
module recv_demux_fifo
  import recv_demux_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 4,
  parameter int ERR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [TYPE_W-1:0]        data_type,
  output logic                     data_ack,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [ERR_W-1:0]         err_cnt
);

  rd_state_e state_reg;
  rd_state_e state_next;

  logic [NUM_CH-1:0] type_hit;
  logic [NUM_CH-1:0] push_vec;
  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] empty_vec;
  logic              valid_type;
  logic              sel_full;
  logic              type_idle;
  logic              push_en;
  logic              err_inc;
  logic [ERR_W-1:0]  err_cnt_reg;

  assign type_idle  = (data_type == TYPE_W'(TYPE_NONE));
  assign valid_type = |type_hit;
  // Full test uses the registered count, so a same-cycle pop does not
  // open a slot until the following cycle.
  assign sel_full   = |(type_hit & full_vec);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign type_hit[gi]  = (data_type == TYPE_W'(gi + 1));
      assign push_vec[gi]  = push_en && type_hit[gi];
      assign out_valid[gi] = ~empty_vec[gi];

      recv_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_vec[gi]),
        .din     (data_in),
        .pop     (out_ready[gi]),
        .dout    (out_data[gi*DATA_W +: DATA_W]),
        .empty   (empty_vec[gi]),
        .full    (full_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The push or error bump only happens on the IDLE->ACK transition, so a
  // long-held type code yields exactly one action per handshake. A full
  // target channel leaves the FSM in IDLE so the CPU can retarget freely.
  always_comb begin
    state_next = state_reg;
    push_en    = 1'b0;
    err_inc    = 1'b0;
    case (state_reg)
      RD_IDLE: begin
        if (!type_idle) begin
          if (valid_type) begin
            if (!sel_full) begin
              push_en    = 1'b1;
              state_next = RD_ACK;
            end
          end else begin
            err_inc    = 1'b1;
            state_next = RD_ACK;
          end
        end
      end
      RD_ACK: begin
        if (type_idle) begin
          state_next = RD_IDLE;
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_reg <= '0;
    end else if (err_inc && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign data_ack = (state_reg == RD_ACK);
  assign ch_full  = full_vec;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_recv_demux_fifo.sv
// Self-checking bench for recv_demux_fifo (DATA_W=32, NUM_CH=2, DEPTH=4, ERR_W=8).
// Inputs change 1 time unit after the rising edge; a negedge monitor pops the
// per-channel scoreboards whenever the DUT will consume a head word.
module tb_recv_demux_fifo;
  import recv_demux_fifo_pkg::*;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 2;
  localparam int TYPE_W = 2;
  localparam int DEPTH  = 4;
  localparam int ERR_W  = 8;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [DATA_W-1:0]        data_in;
  logic [TYPE_W-1:0]        data_type;
  logic                     data_ack;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH-1:0]        ch_full;
  logic [ERR_W-1:0]         err_cnt;

  recv_demux_fifo #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .TYPE_W (TYPE_W),
    .DEPTH  (DEPTH),
    .ERR_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .data_type (data_type),
    .data_ack  (data_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_full   (ch_full),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [DATA_W-1:0] sb0[$];
  logic [DATA_W-1:0] sb1[$];
  int exp_err = 0;

  typedef struct {
    logic [1:0]  dtype;
    logic [31:0] data;
    logic [1:0]  exp_valid;
    logic [31:0] exp_d0;
    logic [7:0]  exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Consumer-side scoreboard: a head word seen with valid&ready here is
  // consumed on the next rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (out_valid[CH_ARP] && out_ready[CH_ARP]) begin
        if (sb0.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL ch0_pop: got %h expected no word outstanding", out_data[31:0]);
        end else begin
          check("ch0_pop", {32'h0, out_data[31:0]}, {32'h0, sb0.pop_front()});
        end
      end
      if (out_valid[CH_IP] && out_ready[CH_IP]) begin
        if (sb1.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL ch1_pop: got %h expected no word outstanding", out_data[63:32]);
        end else begin
          check("ch1_pop", {32'h0, out_data[63:32]}, {32'h0, sb1.pop_front()});
        end
      end
    end
  end

  task automatic start_write(input logic [1:0] t, input logic [31:0] d);
    data_type = t;
    data_in   = d;
  endtask

  // Waits for the acknowledge, records the expected effect, then completes
  // the return-to-zero half of the handshake.
  task automatic finish_write(input logic [1:0] t, input logic [31:0] d, input string tag);
    int n;
    n = 0;
    while (data_ack !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_ack_rise"}, {63'h0, data_ack}, 64'h1);
    if (data_ack === 1'b1) begin
      if (t == 2'd1) sb0.push_back(d);
      else if (t == 2'd2) sb1.push_back(d);
      else if (exp_err < 255) exp_err++;
    end
    data_type = 2'd0;
    n = 0;
    while (data_ack !== 1'b0 && n < 5) begin
      cyc();
      n++;
    end
    check({tag, "_ack_fall"}, {63'h0, data_ack}, 64'h0);
  endtask

  task automatic write(input logic [1:0] t, input logic [31:0] d, input string tag);
    start_write(t, d);
    finish_write(t, d, tag);
  endtask

  task automatic drain(input logic [1:0] mask, input string tag);
    out_ready = mask;
    repeat (12) cyc();
    out_ready = 2'b00;
    check({tag, "_sb0_left"}, 64'(sb0.size()), 64'h0);
    check({tag, "_sb1_left"}, 64'(sb1.size()), 64'h0);
    check({tag, "_valid"}, {62'h0, out_valid}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF, 8'd0};
    vecs[1] = '{2'd3, 32'h0BAD_0001, 2'b01, 32'hDEAD_BEEF, 8'd1};
    vecs[2] = '{2'd3, 32'h0BAD_0002, 2'b01, 32'hDEAD_BEEF, 8'd2};
    vecs[3] = '{2'd3, 32'h0BAD_0003, 2'b01, 32'hDEAD_BEEF, 8'd3};
    vecs[4] = '{2'd2, 32'h1111_1111, 2'b11, 32'hDEAD_BEEF, 8'd3};
    vecs[5] = '{2'd1, 32'h2222_2222, 2'b11, 32'hDEAD_BEEF, 8'd3};

    reset_n   = 1'b0;
    data_in   = '0;
    data_type = '0;
    out_ready = '0;
    repeat (3) cyc();
    check("rst_ack", {63'h0, data_ack}, 64'h0);
    check("rst_valid", {62'h0, out_valid}, 64'h0);
    check("rst_data", out_data, 64'h0);
    check("rst_full", {62'h0, ch_full}, 64'h0);
    check("rst_err", {56'h0, err_cnt}, 64'h0);
    reset_n = 1'b1;
    cyc();

    // Table: basic routing and invalid types, no consumers ready.
    for (int i = 0; i < 6; i++) begin
      write(vecs[i].dtype, vecs[i].data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_valid", i), {62'h0, out_valid}, {62'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_err", i), {56'h0, err_cnt}, {56'h0, vecs[i].exp_err});
      if (vecs[i].exp_valid[0])
        check($sformatf("vec%0d_d0", i), {32'h0, out_data[31:0]}, {32'h0, vecs[i].exp_d0});
    end
    drain(2'b11, "table_drain");

    // Fill ch1, stall the fifth word, open one slot with a single pop.
    for (int k = 0; k < 4; k++) write(2'd2, 32'hA000_0000 + k, $sformatf("fill%0d", k));
    check("fill_full", {62'h0, ch_full}, 64'h2);
    start_write(2'd2, 32'hA000_0004);
    repeat (3) cyc();
    check("stall_ack", {63'h0, data_ack}, 64'h0);
    check("stall_full", {62'h0, ch_full}, 64'h2);
    out_ready = 2'b10;
    cyc();
    out_ready = 2'b00;
    check("pop_same_cycle_ack", {63'h0, data_ack}, 64'h0);
    finish_write(2'd2, 32'hA000_0004, "stall_w5");
    check("w5_full", {62'h0, ch_full}, 64'h2);
    drain(2'b10, "stall_drain");

    // Saturating error counter.
    for (int k = 0; k < 260; k++) write(2'd3, k, "inv");
    check("err_sat", {56'h0, err_cnt}, 64'd255);
    check("err_sat_model", {56'h0, err_cnt}, 64'(exp_err));
    check("err_no_valid", {62'h0, out_valid}, 64'h0);

    // Long-held type code after acknowledge: exactly one push.
    start_write(2'd1, 32'h4444_0001);
    for (int n = 0; n < 20 && data_ack !== 1'b1; n++) cyc();
    check("hold_ack_rise", {63'h0, data_ack}, 64'h1);
    sb0.push_back(32'h4444_0001);
    for (int n = 0; n < 10; n++) begin
      cyc();
      check($sformatf("hold_ack_%0d", n), {63'h0, data_ack}, 64'h1);
    end
    data_type = 2'd0;
    cyc();
    check("hold_ack_fall", {63'h0, data_ack}, 64'h0);
    check("hold_valid", {62'h0, out_valid}, 64'h1);
    drain(2'b01, "hold_drain");

    // Full ch0, then continuous consumer with back-to-back writes.
    for (int k = 0; k < 4; k++) write(2'd1, 32'h5500_0000 + k, $sformatf("bb_fill%0d", k));
    check("bb_full", {62'h0, ch_full}, 64'h1);
    out_ready = 2'b01;
    for (int k = 4; k < 12; k++) write(2'd1, 32'h5500_0000 + k, $sformatf("bb%0d", k));
    drain(2'b01, "bb_drain");

    // Reset in the middle of a handshake discards queued words.
    for (int k = 0; k < 3; k++) write(2'd1, 32'h6600_0000 + k, $sformatf("rq%0d", k));
    start_write(2'd1, 32'h6600_0003);
    for (int n = 0; n < 20 && data_ack !== 1'b1; n++) cyc();
    check("rq_in_ack", {63'h0, data_ack}, 64'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", {63'h0, data_ack}, 64'h0);
    check("mid_rst_valid", {62'h0, out_valid}, 64'h0);
    check("mid_rst_data", out_data, 64'h0);
    check("mid_rst_full", {62'h0, ch_full}, 64'h0);
    check("mid_rst_err", {56'h0, err_cnt}, 64'h0);
    sb0.delete();
    sb1.delete();
    exp_err   = 0;
    data_type = 2'd0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    check("post_rst_valid", {62'h0, out_valid}, 64'h0);
    write(2'd1, 32'h7777_0001, "post_rst_w");
    check("post_rst_head", {32'h0, out_data[31:0]}, 64'h7777_0001);
    drain(2'b01, "post_rst_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
